key_event_gen: RTL and testbench

Parametrised multi-channel push-button front end: synchronises NUM_KEYS raw key inputs, debounces each one and turns it into single-cycle event pulses. Events are press, release, long-press and auto-repeat. It sits between the board key pins and the control logic, such as the FIFO transfer/send strobes and the LED status logic. It replaces the ad-hoc per-key delay-line edge detectors with one uniform, configurable block.

---
 rtl/key_event_pkg.sv | 19 +
 rtl/key_event_chan.sv | 126 ++++++++++++
 rtl/key_event_gen.sv | 55 +++++
 tb/tb_key_event_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event front end.
package key_event_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED  = 2'd0,
    KEY_HELD      = 2'd1,
    KEY_REPEATING = 2'd2
  } key_fsm_e;

  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: pin synchroniser, debounce, hold/repeat FSM and pulse registers.
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int KEY_ACTIVE_LOW    = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pin,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic event_next
);

  localparam int DEB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);
  localparam logic IDLE_LEVEL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [DEB_W-1:0]       deb_cnt_r;
  logic [HOLD_W-1:0]      hold_cnt_r;
  key_fsm_e               state_r;
  logic                   long_done_r;
  logic pressed_s, differ_s, accept_s, long_hit_s, rep_hit_s;

  // Event decisions from the registered state and the synchronised level
  always_comb begin
    pressed_s  = sync_r[SYNC_STAGES-1] ^ IDLE_LEVEL;
    differ_s   = pressed_s ^ key_state;
    accept_s   = differ_s & (deb_cnt_r == DEB_LAST);
    long_hit_s = (state_r == KEY_HELD) & ~long_done_r & (hold_cnt_r == LONG_LAST);
    rep_hit_s  = (state_r == KEY_REPEATING) & (hold_cnt_r == REP_LAST);
    event_next = accept_s | long_hit_s | rep_hit_s;
  end

  // Synchroniser chain, parked at the not-pressed pin level on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key_pin};
    end
  end

  // Debounce counter, channel FSM, hold counter and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_r     <= '0;
      hold_cnt_r    <= '0;
      state_r       <= KEY_RELEASED;
      long_done_r   <= 1'b0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      if (!differ_s || accept_s) begin
        deb_cnt_r <= '0;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end

      // An accepted level change wins over any hold threshold in the same cycle
      if (accept_s) begin
        key_state   <= ~key_state;
        hold_cnt_r  <= '0;
        long_done_r <= 1'b0;
        if (key_state) begin
          release_pulse <= 1'b1;
          state_r       <= KEY_RELEASED;
        end else begin
          press_pulse <= 1'b1;
          state_r     <= KEY_HELD;
        end
      end else begin
        case (state_r)
          KEY_HELD: begin
            if (long_done_r) begin
              hold_cnt_r <= hold_cnt_r;
            end else if (long_hit_s) begin
              long_pulse <= 1'b1;
              if (REPEAT_CYCLES == 0) begin
                long_done_r <= 1'b1;
              end else begin
                hold_cnt_r <= '0;
                state_r    <= KEY_REPEATING;
              end
            end else begin
              hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end
          end
          KEY_REPEATING: begin
            if (rep_hit_s) begin
              repeat_pulse <= 1'b1;
              hold_cnt_r   <= '0;
            end else begin
              hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end
          end
          default: begin
            hold_cnt_r <= '0;
            state_r    <= KEY_RELEASED;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Multi-channel push-button front end: NUM_KEYS independent channels plus a
// registered any_event flag coincident with the per-channel pulses.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS          = 5,
  parameter int KEY_ACTIVE_LOW    = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                any_event
);

  logic [NUM_KEYS-1:0] event_next_s;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_event_chan #(
      .KEY_ACTIVE_LOW   (KEY_ACTIVE_LOW),
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .key_pin      (key_in[k]),
      .key_state    (key_state[k]),
      .press_pulse  (press_pulse[k]),
      .release_pulse(release_pulse[k]),
      .long_pulse   (long_pulse[k]),
      .repeat_pulse (repeat_pulse[k]),
      .event_next   (event_next_s[k])
    );
  end

  // any_event is registered from the channels' next-pulse terms so it lines up with the pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      any_event <= 1'b0;
    end else begin
      any_event <= |event_next_s;
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with a timestamp-based reference model.
module tb_key_event_gen;

  localparam int NK   = 5;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic          clk;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic          any_event;

  key_event_gen #(
    .NUM_KEYS(NK), .KEY_ACTIVE_LOW(1), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(key_state),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .any_event(any_event)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  bit model_on = 1'b0;

  // Reference model: pin history, debounce run length, and press timestamps
  logic [NK-1:0] pin_hist [SYNC];
  logic [NK-1:0] st_m;
  int            run_m    [NK];
  int            press_at [NK];
  logic [NK-1:0] e_state, e_press, e_rel, e_long, e_rep;
  logic          e_any;

  always @(posedge clk) begin : model_p
    logic [NK-1:0] lvl, ns, np, nr, nl, nq;
    int r, age;
    edge_n <= edge_n + 1;
    if (rst) begin
      for (int s = 0; s < SYNC; s++) pin_hist[s] <= '1;
      for (int c = 0; c < NK; c++) run_m[c] <= 0;
      st_m <= '0; e_state <= '0; e_press <= '0; e_rel <= '0;
      e_long <= '0; e_rep <= '0; e_any <= 1'b0; model_on <= 1'b1;
    end else begin
      pin_hist[0] <= key_in;
      for (int s = 1; s < SYNC; s++) pin_hist[s] <= pin_hist[s-1];
      lvl = ~pin_hist[SYNC-1];
      ns = st_m; np = '0; nr = '0; nl = '0; nq = '0;
      for (int c = 0; c < NK; c++) begin
        if (lvl[c] != st_m[c]) begin
          r = run_m[c] + 1;
          if (r == DEB) begin
            ns[c] = lvl[c];
            run_m[c] <= 0;
            if (lvl[c]) begin
              np[c] = 1'b1;
              press_at[c] <= edge_n + 1;
            end else begin
              nr[c] = 1'b1;
            end
          end else begin
            run_m[c] <= r;
          end
        end else begin
          run_m[c] <= 0;
        end
        if (!(np[c] | nr[c]) && st_m[c]) begin
          age = edge_n + 1 - press_at[c];
          if (age == LONG) nl[c] = 1'b1;
          else if (REP > 0 && age > LONG && ((age - LONG) % REP) == 0) nq[c] = 1'b1;
        end
      end
      st_m <= ns; e_state <= ns; e_press <= np; e_rel <= nr;
      e_long <= nl; e_rep <= nq; e_any <= |{np, nr, nl, nq};
    end
  end

  // Per-cycle comparison against the model and event logging for directed checks
  int n_press [NK], last_press [NK], n_rel [NK], last_rel [NK], n_long [NK], last_long [NK];
  int rep0_q [$];

  initial begin
    for (int c = 0; c < NK; c++) begin
      n_press[c] = 0; last_press[c] = -1; n_rel[c] = 0;
      last_rel[c] = -1; n_long[c] = 0; last_long[c] = -1;
    end
    forever begin
      @(negedge clk);
      if (model_on) begin
        n_checks++;
        if ({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, any_event} !==
            {e_state, e_press, e_rel, e_long, e_rep, e_any}) begin
          n_fail++;
          $display("FAIL model_cmp @%0d: dut st=%b pr=%b rl=%b lg=%b rp=%b any=%b, expected st=%b pr=%b rl=%b lg=%b rp=%b any=%b",
                   edge_n, key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, any_event,
                   e_state, e_press, e_rel, e_long, e_rep, e_any);
        end
        for (int c = 0; c < NK; c++) begin
          if (press_pulse[c] === 1'b1)   begin n_press[c]++; last_press[c] = edge_n; end
          if (release_pulse[c] === 1'b1) begin n_rel[c]++;   last_rel[c]   = edge_n; end
          if (long_pulse[c] === 1'b1)    begin n_long[c]++;  last_long[c]  = edge_n; end
        end
        if (repeat_pulse[0] === 1'b1) rep0_q.push_back(edge_n);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic go(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  int t0, tb, t1, pr, tr, tp, rd, tm;

  initial begin
    rst = 1'b1;
    key_in = '1;
    go(2);
    rst = 1'b0;
    check("reset_key_state", int'(key_state), 0);
    check("reset_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    check("reset_any_event", int'(any_event), 0);
    go(5);

    // Clean press on key 0, then long press and three repeats
    t0 = edge_n;
    key_in[0] = 1'b0;
    go(t0 + 5);
    check("clean_state_before", int'(key_state[0]), 0);
    go(t0 + 6);
    check("clean_state_rise", int'(key_state[0]), 1);
    go(t0 + 7);
    check("clean_press_time", last_press[0], t0 + 6);
    go(t0 + 27);
    check("clean_long_time", last_long[0], t0 + 26);
    go(t0 + 51);
    check("clean_repeat_count", rep0_q.size(), 3);
    for (int k = 0; k < rep0_q.size(); k++) check("clean_repeat_time", rep0_q[k], t0 + 34 + 8 * k);
    key_in[0] = 1'b1;
    tr = edge_n;
    go(tr + 7);
    check("clean_release_time", last_rel[0], tr + 6);

    // Bounce on key 1: low 3, high 1, then low and held
    tb = edge_n;
    key_in[1] = 1'b0;
    go(tb + 3);
    key_in[1] = 1'b1;
    go(tb + 4);
    key_in[1] = 1'b0;
    t1 = edge_n;
    go(t1 + 7);
    check("bounce_press_count", n_press[1], 1);
    check("bounce_press_time", last_press[1], t1 + 6);

    // Release before long press on key 1
    pr = t1 + 6;
    go(pr + 10);
    key_in[1] = 1'b1;
    tr = edge_n;
    go(tr + 7);
    check("early_release_time", last_rel[1], tr + 6);
    go(pr + 30);
    check("early_release_no_long", n_long[1], 0);

    // Release accepted in the same cycle the long threshold is reached on key 3
    tp = edge_n;
    key_in[3] = 1'b0;
    pr = tp + 6;
    go(pr + 14);
    key_in[3] = 1'b1;
    go(pr + 21);
    check("collision_release_time", last_rel[3], pr + 20);
    check("collision_no_long", n_long[3], 0);

    // Reset while key 2 is repeating
    tp = edge_n;
    key_in[2] = 1'b0;
    pr = tp + 6;
    go(pr + 24);
    check("midhold_long_seen", last_long[2], pr + 20);
    rst = 1'b1;
    go(pr + 25);
    rst = 1'b0;
    rd = edge_n;
    check("midhold_reset_state", int'(key_state), 0);
    check("midhold_reset_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse, any_event}), 0);
    go(rd + 7);
    check("midhold_repress_time", last_press[2], rd + 6);
    check("midhold_press_count", n_press[2], 2);
    key_in[2] = 1'b1;
    go(edge_n + 10);

    // All keys pressed together
    key_in = '0;
    tm = edge_n;
    go(tm + 5);
    check("multi_any_before", int'(any_event), 0);
    go(tm + 6);
    check("multi_press_vec", int'(press_pulse), 31);
    check("multi_any_on", int'(any_event), 1);
    go(tm + 7);
    check("multi_any_after", int'(any_event), 0);
    check("multi_press_after", int'(press_pulse), 0);
    key_in = '1;
    go(edge_n + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
